if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage of the RV32I core: owns the 16-bit program counter, issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned words. It presents `instr`/`pc` pairs to the decode stage (`ID_top`), honours decode's `stall`, and takes taken-branch/jump redirects (`dest_pc`) back from decode, discarding wrong-path words.

## Interface
- `RESET_PC`, 16'h0000, first fetch address after reset
- `MAX_OUTSTANDING`, 2, maximum in-flight plus buffered words (credit limit), range 1..2
- `clk  in  1  rising-edge clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `imem_req  out  1  fetch request valid`
- `imem_addr  out  16  fetch byte address, bits [1:0] always 0`
- `imem_gnt  in  1  request accepted this cycle`
- `imem_rvalid  in  1  response word valid, in request order, ≥1 cycle after grant`
- `imem_rdata  in  32  response instruction word`
- `redirect_valid  in  1  decode resolved a taken branch/jump`
- `redirect_pc  in  16  new fetch address (decode `dest_pc`)`
- `stall  in  1  decode cannot accept; hold output`
- `id_valid  out  1  `id_instr`/`id_pc` carry a real instruction`
- `id_instr  out  32  instruction to decode`
- `id_pc  out  16  address of `id_instr``

## Operation
- State: `pc`, outstanding counter (0..2), discard counter (0..2), 2-entry FIFO of {pc, instr}, output register.
- Issue: `imem_req = (outstanding + fifo_count < MAX_OUTSTANDING) && !redirect_valid`; `imem_addr = pc`. On `imem_req && imem_gnt`: `pc <= pc + 4` (wraps 16'hFFFC→16'h0000), outstanding +1, tag pc pushed to in-flight pc queue.
- Response: on `imem_rvalid`, outstanding −1. If discard counter ≠ 0: drop word, discard −1. Else deliver with its tag pc.
- Delivery: if `!stall` and FIFO empty, response bypasses into output register; otherwise pushed to FIFO. Credit limit guarantees FIFO never overflows.
- Output: when `!stall`, output register loads FIFO head (pop) if non-empty, else bypass word, else bubble (`id_valid=0`, `id_instr=32'h00000013`, `id_pc` held). When `stall`, output register holds.
- Redirect (priority over stall and everything else): `pc <= {redirect_pc[15:2],2'b00}`; FIFO cleared; `id_valid <= 0`, `id_instr <= NOP`; discard counter ← outstanding after this cycle's response is accounted for (a response in the redirect cycle is itself dropped); no request issued in the redirect cycle.
- `imem_rvalid` with outstanding = 0 is a protocol error: ignored (assertion in simulation).

## Timing
- Reset (async assert): `pc=RESET_PC`, `imem_req=0` while `rst_n=0`, `id_valid=0`, `id_instr=32'h00000013`, `id_pc=RESET_PC`, all counters 0, FIFO empty.
- First cycle after release: `imem_req=1`, `imem_addr=RESET_PC`.
- Latency: `imem_rvalid` in cycle N → `id_valid=1` in N+1 (bypass path, no stall).
- Sustained throughput one instruction/cycle with single-cycle memory and no stall.
- Redirect in cycle N → `imem_req=1` at `redirect_pc` in N+1; first correct-path instruction no earlier than N+3.
- Reset asserted mid-fetch: all state cleared immediately; in-flight responses after release are not expected (memory is reset from the same `rst_n`).

## Configuration
- `IF_PERF_CNT_EN` defined: adds outputs `perf_fetched` (16 bits, +1 per word delivered to the output register) and `perf_flushed` (16 bits, +1 per discarded or FIFO-cleared word, output-register kill included); both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- `if_pkg`: `PC_W=16`, `INSTR_W=32`, `NOP_INSTR=32'h00000013`, `typedef struct packed {logic [15:0] pc; logic [31:0] instr;} fetch_entry_t`.
- Sub-module `if_fetch_fifo`: 2-entry `fetch_entry_t` FIFO with push, pop, flush, count; top instantiates it once.

## Test plan
- Reset release, 1-cycle memory, no stall → addresses 0,4,8,… each cycle; `id_pc` 0,4,8 with `id_instr` matching memory, first `id_valid` 2 cycles after release.
- `stall` held 4 cycles at `id_pc=8` → output frozen at 8, `imem_req` drops once 2 words buffered; after release, `id_pc` 12,16 in consecutive cycles, no loss or duplicate.
- Redirect to 16'h0040 with 2 words outstanding → both responses dropped, `id_valid=0` until word at 16'h0040 arrives; next `id_pc` sequence 40,44.
- Redirect with `redirect_pc=16'h0046` while `stall=1` → fetch at 16'h0044, FIFO cleared, `id_valid=0` next cycle.
- PC at 16'hFFFC → next `imem_addr=16'h0000`.
- With `IF_PERF_CNT_EN`: 10 delivered, one redirect killing 2 in flight plus output register → `perf_fetched=10`, `perf_flushed=3`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared widths, NOP encoding and the fetch-buffer payload for the instruction fetch stage.
package if_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and the decode output register.
module if_fetch_fifo
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_c,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head_c = mem[rd_ptr];

  // Flush wins; push and pop may occur in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch: PC, credit-limited imem requests, response buffering and redirect flush.
// Optional IF_PERF_CNT_EN adds saturating perf_fetched / perf_flushed counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC        = 16'h0000,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);

  logic [PC_W-1:0] pc;
  logic [1:0]      outstanding;
  logic [1:0]      discard;
  logic [PC_W-1:0] tag_q [2];
  logic            tag_wr;
  logic            tag_rd;

  fetch_entry_t    fifo_head;
  fetch_entry_t    rsp_entry;
  logic [1:0]      fifo_count;
  logic            fifo_push;
  logic            fifo_pop;
  logic            req_fire;
  logic            rsp_valid;
  logic            rsp_keep;
  logic [1:0]      out_next;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit counts in-flight plus buffered words; the output register is not part of it.
  assign imem_req  = rst_n && !redirect_valid &&
                     ((32'(outstanding) + 32'(fifo_count)) < MAX_OUTSTANDING);
  assign imem_addr = pc;

  assign req_fire  = imem_req && imem_gnt;
  assign rsp_valid = imem_rvalid && (outstanding != 2'd0);
  assign rsp_keep  = rsp_valid && (discard == 2'd0) && !redirect_valid;
  assign rsp_entry = {tag_q[tag_rd], imem_rdata};
  assign out_next  = outstanding + 2'(req_fire) - 2'(rsp_valid);

  assign fifo_pop  = !redirect_valid && !stall && (fifo_count != 2'd0);
  assign fifo_push = rsp_keep && (stall || (fifo_count != 2'd0));

  if_fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_c    (fifo_head),
    .count     (fifo_count)
  );

  // PC, credit/discard bookkeeping, in-flight tag queue and decode output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      tag_q[0]    <= '0;
      tag_q[1]    <= '0;
      tag_wr      <= 1'b0;
      tag_rd      <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= RESET_PC;
    end else begin
      outstanding <= out_next;
      if (req_fire) begin
        tag_q[tag_wr] <= pc;
        tag_wr        <= ~tag_wr;
      end
      if (rsp_valid) begin
        tag_rd <= ~tag_rd;
      end
      if (redirect_valid) begin
        pc       <= {redirect_pc[PC_W-1:2], 2'b00};
        discard  <= out_next;
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else begin
        if (req_fire) begin
          pc <= pc + 16'd4;
        end
        if (rsp_valid && (discard != 2'd0)) begin
          discard <= discard - 2'd1;
        end
        if (!stall) begin
          if (fifo_count != 2'd0) begin
            id_valid <= 1'b1;
            id_instr <= fifo_head.instr;
            id_pc    <= fifo_head.pc;
          end else if (rsp_keep) begin
            id_valid <= 1'b1;
            id_instr <= rsp_entry.instr;
            id_pc    <= rsp_entry.pc;
          end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        fetched_inc;
  logic [2:0]  flushed_add;
  logic [16:0] flushed_sum;

  assign fetched_inc = !redirect_valid && !stall && ((fifo_count != 2'd0) || rsp_keep);
  assign flushed_add = redirect_valid
                     ? (3'(fifo_count) + 3'(rsp_valid) + 3'(id_valid))
                     : 3'(rsp_valid && (discard != 2'd0));
  assign flushed_sum = 17'(perf_flushed) + 17'(flushed_add);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 16'd0;
      perf_flushed <= 16'd0;
    end else begin
      if (fetched_inc && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

  rvalid_needs_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding != 2'd0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: in-order memory model with configurable latency.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  pend_t        pend [$];
  fetch_entry_t exp_q [$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          model_fetched = 0;
  int          model_flushed = 0;
  logic        last_req;
  logic [15:0] last_addr;
  logic        prev_valid;
  logic [31:0] prev_instr;
  logic [15:0] prev_pc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} ^ 32'h5A5A0000;
  endfunction

  // One clock: drive inputs at negedge, grant whatever is requested, check outputs after the edge.
  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
    logic         idv_before;
    fetch_entry_t e;
    @(negedge clk);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    imem_gnt   = imem_req;
    last_req   = imem_req;
    last_addr  = imem_addr;
    idv_before = id_valid;
    @(posedge clk);
    cyc++;
    #1;
    if (imem_rvalid) void'(pend.pop_front());
    if (rd) begin
      model_flushed += exp_q.size() + (idv_before ? 1 : 0);
      exp_q.delete();
    end
    if (last_req) begin
      pend.push_back('{addr: last_addr, due: cyc + lat - 1});
      exp_q.push_back('{pc: last_addr, instr: mem_word(last_addr)});
    end
    if (rd) begin
      check_eq("redir_valid", 32'(id_valid), 32'd0);
      check_eq("redir_nop", id_instr, NOP_INSTR);
    end else if (st) begin
      check_eq("stall_hold_valid", 32'(id_valid), 32'(prev_valid));
      check_eq("stall_hold_pc", 32'(id_pc), 32'(prev_pc));
      check_eq("stall_hold_instr", id_instr, prev_instr);
    end else if (id_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", 32'(id_pc), 32'(e.pc));
        check_eq("sb_instr", id_instr, e.instr);
        model_fetched++;
      end
    end
    prev_valid = id_valid;
    prev_pc    = id_pc;
    prev_instr = id_instr;
  endtask

  task automatic clear_model();
    pend.delete();
    exp_q.delete();
    model_fetched = 0;
    model_flushed = 0;
    prev_valid    = 1'b0;
    prev_pc       = 16'h0000;
    prev_instr    = NOP_INSTR;
    imem_rvalid   = 1'b0;
    imem_gnt      = 1'b0;
    stall         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc   = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
    check_eq({tag, "_valid"}, 32'(id_valid), 32'd0);
    check_eq({tag, "_instr"}, id_instr, NOP_INSTR);
    check_eq({tag, "_pc"}, 32'(id_pc), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    imem_rdata = '0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset release, single-cycle memory, no stall.
    cycle(0, 0, 16'h0);
    check_eq("first_req", 32'(last_req), 32'd1);
    check_eq("first_addr", 32'(last_addr), 32'h0);
    check_eq("first_valid_early", 32'(id_valid), 32'd0);
    cycle(0, 0, 16'h0);
    check_eq("latency_valid", 32'(id_valid), 32'd1);
    check_eq("latency_pc", 32'(id_pc), 32'h0);
    cycle(0, 0, 16'h0);
    check_eq("tput_pc4", 32'(id_pc), 32'h4);
    cycle(0, 0, 16'h0);
    check_eq("tput_pc8", 32'(id_pc), 32'h8);

    // Stall four cycles at pc 8: credit fills, then releases with no loss.
    repeat (4) cycle(1, 0, 16'h0);
    check_eq("stall_req_drop", 32'(last_req), 32'd0);
    cycle(0, 0, 16'h0);
    check_eq("unstall_pc12", 32'(id_pc), 32'h0C);
    cycle(0, 0, 16'h0);
    check_eq("unstall_pc16", 32'(id_pc), 32'h10);
    repeat (3) cycle(0, 0, 16'h0);

    // Redirect with two words in flight on a two-cycle memory.
    lat = 2;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(0, 0, 16'h0);
    check_eq("two_in_flight", 32'(pend.size()), 32'd2);
    cycle(0, 1, 16'h0040);
    check_eq("redir_no_req", 32'(last_req), 32'd0);
    lat = 1;
    cycle(0, 0, 16'h0);
    check_eq("redir_req_next", 32'(last_req), 32'd1);
    check_eq("redir_addr_next", 32'(last_addr), 32'h40);
    for (int i = 0; i < 10 && !id_valid; i++) cycle(0, 0, 16'h0);
    check_eq("redir_first_valid", 32'(id_valid), 32'd1);
    check_eq("redir_first_pc", 32'(id_pc), 32'h40);
    cycle(0, 0, 16'h0);
    check_eq("redir_second_pc", 32'(id_pc), 32'h44);

    // Redirect to an unaligned target while stalled with a full buffer.
    repeat (3) cycle(1, 0, 16'h0);
    cycle(1, 1, 16'h0046);
    cycle(0, 0, 16'h0);
    check_eq("stall_redir_addr", 32'(last_addr), 32'h44);
    for (int i = 0; i < 10 && !id_valid; i++) cycle(0, 0, 16'h0);
    check_eq("stall_redir_first_pc", 32'(id_pc), 32'h44);

    // PC wrap at the top of the address space.
    cycle(0, 1, 16'hFFF8);
    cycle(0, 0, 16'h0);
    check_eq("wrap_addr_fff8", 32'(last_addr), 32'hFFF8);
    cycle(0, 0, 16'h0);
    check_eq("wrap_addr_fffc", 32'(last_addr), 32'hFFFC);
    cycle(0, 0, 16'h0);
    check_eq("wrap_addr_0000", 32'(last_addr), 32'h0000);
    repeat (4) cycle(0, 0, 16'h0);

    // Asynchronous reset in the middle of fetching.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    clear_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(0, 0, 16'h0);
    check_eq("midreset_addr", 32'(last_addr), 32'h0);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetched_reset", 32'(perf_fetched), 32'd0);
`endif

    // Deliveries then a flushing redirect, then drain.
    lat = 2;
    for (int i = 0; i < 60 && model_fetched < 10; i++) cycle(0, 0, 16'h0);
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(0, 0, 16'h0);
    cycle(0, 1, 16'h0100);
    lat = 1;
    for (int i = 0; i < 10 && !id_valid; i++) cycle(0, 0, 16'h0);
    check_eq("perf_redir_pc", 32'(id_pc), 32'h100);
    repeat (3) cycle(0, 0, 16'h0);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetched", 32'(perf_fetched), 32'(model_fetched));
    check_eq("perf_flushed", 32'(perf_flushed), 32'(model_flushed));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
